// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - registered ALU operand select with MEM/WB forwarding and stall counter
// Forwarding is built only when ALU_OPERAND_FWD_EN is defined; otherwise fwd_* inputs are ignored.
module alu_operand_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [RA_W-1:0]  rs1_a_i,
  input  logic [RA_W-1:0]  rs2_a_i,
  input  logic [XLEN-1:0]  rs1_d_i,
  input  logic [XLEN-1:0]  rs2_d_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [1:0]       alu1_sel_i,
  input  logic [1:0]       alu2_sel_i,
  input  logic             fwd_mem_we_i,
  input  logic             fwd_wb_we_i,
  input  logic [RA_W-1:0]  fwd_mem_rd_i,
  input  logic [RA_W-1:0]  fwd_wb_rd_i,
  input  logic [XLEN-1:0]  fwd_mem_d_i,
  input  logic [XLEN-1:0]  fwd_wb_d_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  alu_in1_o,
  output logic [XLEN-1:0]  alu_in2_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  input  logic             stall_clr_i
);

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  alu_in1_q, alu_in1_d;
  logic [XLEN-1:0]  alu_in2_q, alu_in2_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [XLEN-1:0]  rs1_res, rs2_res;
  logic [XLEN-1:0]  op1, op2;
  logic             capture;
  logic             stalled;

  // MEM beats WB; x0 is hardwired and must never pick up forwarded data.
  always_comb begin
    rs1_res = rs1_d_i;
    rs2_res = rs2_d_i;
`ifdef ALU_OPERAND_FWD_EN
    if (rs1_a_i != '0 && fwd_mem_we_i && fwd_mem_rd_i == rs1_a_i)
      rs1_res = fwd_mem_d_i;
    else if (rs1_a_i != '0 && fwd_wb_we_i && fwd_wb_rd_i == rs1_a_i)
      rs1_res = fwd_wb_d_i;
    if (rs2_a_i != '0 && fwd_mem_we_i && fwd_mem_rd_i == rs2_a_i)
      rs2_res = fwd_mem_d_i;
    else if (rs2_a_i != '0 && fwd_wb_we_i && fwd_wb_rd_i == rs2_a_i)
      rs2_res = fwd_wb_d_i;
`endif
  end

`ifndef ALU_OPERAND_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{rs1_a_i, rs2_a_i, fwd_mem_we_i, fwd_wb_we_i, fwd_mem_rd_i,
                        fwd_wb_rd_i, fwd_mem_d_i, fwd_wb_d_i};
`endif

  always_comb begin
    op1 = '0;
    case (alu1_sel_i)
      2'd0:    op1 = rs1_res;
      2'd1:    op1 = pc_i;
      default: op1 = '0;
    endcase
  end

  always_comb begin
    op2 = '0;
    case (alu2_sel_i)
      2'd0:    op2 = rs2_res;
      2'd1:    op2 = imm_i;
      2'd2:    op2 = XLEN'(4);
      default: op2 = '0;
    endcase
  end

  assign in_ready_o = !flush_i && (!out_valid_q || out_ready_i);
  assign capture    = in_valid_i && in_ready_o;
  assign stalled    = out_valid_q && !out_ready_i;

  always_comb begin
    out_valid_d = out_valid_q;
    alu_in1_d   = alu_in1_q;
    alu_in2_d   = alu_in2_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i)
      out_valid_d = 1'b0;
    else if (capture)
      out_valid_d = 1'b1;
    else if (out_valid_q && out_ready_i)
      out_valid_d = 1'b0;
    if (capture) begin
      alu_in1_d = op1;
      alu_in2_d = op2;
    end
    if (stall_clr_i)
      stall_cnt_d = '0;
    else if (stalled && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign alu_in1_o   = alu_in1_q;
  assign alu_in2_o   = alu_in2_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed bench for alu_operand_stage with a behavioural reference model
// Expectations follow ALU_OPERAND_FWD_EN the same way the design does.
module tb_alu_operand_stage;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef ALU_OPERAND_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, flush, out_valid, out_ready, stall_clr;
  logic [4:0] rs1_a, rs2_a, mem_rd, wb_rd;
  logic [31:0] rs1_d, rs2_d, pc, imm, mem_d, wb_d, alu_in1, alu_in2;
  logic [1:0] a1s, a2s;
  logic mem_we, wb_we;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(32), .RA_W(5), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .rs1_a_i(rs1_a), .rs2_a_i(rs2_a), .rs1_d_i(rs1_d), .rs2_d_i(rs2_d),
    .pc_i(pc), .imm_i(imm), .alu1_sel_i(a1s), .alu2_sel_i(a2s),
    .fwd_mem_we_i(mem_we), .fwd_wb_we_i(wb_we), .fwd_mem_rd_i(mem_rd), .fwd_wb_rd_i(wb_rd),
    .fwd_mem_d_i(mem_d), .fwd_wb_d_i(wb_d), .flush_i(flush), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .alu_in1_o(alu_in1), .alu_in2_o(alu_in2),
    .stall_cnt_o(stall_cnt), .stall_clr_i(stall_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: what the stage must hold after each edge.
  logic m_valid;
  logic [31:0] m_in1, m_in2;
  int m_cnt;

  function automatic logic [31:0] src(input logic [4:0] a, input logic [31:0] d);
    if (FWD_ON && a != 0 && mem_we && mem_rd == a) return mem_d;
    if (FWD_ON && a != 0 && wb_we && wb_rd == a) return wb_d;
    return d;
  endfunction

  function automatic logic [31:0] want1();
    if (a1s == 0) return src(rs1_a, rs1_d);
    if (a1s == 1) return pc;
    return 0;
  endfunction

  function automatic logic [31:0] want2();
    if (a2s == 0) return src(rs2_a, rs2_d);
    if (a2s == 1) return imm;
    if (a2s == 2) return 4;
    return 0;
  endfunction

  function automatic logic m_ready();
    return !flush && (!m_valid || out_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_in1 <= 0;
      m_in2 <= 0;
      m_cnt <= 0;
    end else begin
      if (flush) m_valid <= 1'b0;
      else if (in_valid && m_ready()) m_valid <= 1'b1;
      else if (out_ready) m_valid <= 1'b0;
      if (in_valid && m_ready()) begin
        m_in1 <= want1();
        m_in2 <= want2();
      end
      if (stall_clr) m_cnt <= 0;
      else if (m_valid && !out_ready && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("cmp_out_valid", 32'(out_valid), 32'(m_valid));
      chk("cmp_in_ready", 32'(in_ready), 32'(m_ready()));
      if (m_valid) begin
        chk("cmp_alu_in1", alu_in1, m_in1);
        chk("cmp_alu_in2", alu_in2, m_in2);
      end
      chk("cmp_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rs2_vec [5] = '{32'd10, 32'd3, 32'hFFFF_FFFC, 32'd4, 32'hFFFF_FFF0};
  logic [31:0] imm_vec [6] = '{32'd0, 32'd1, 32'd2, 32'd10, 32'hFFFF_FFF0, 32'hFFFF_FFFC};

  initial begin
    rst_n = 1'b0; in_valid = 0; flush = 0; out_ready = 1; stall_clr = 0;
    rs1_a = 0; rs2_a = 0; rs1_d = 0; rs2_d = 0; pc = 0; imm = 0; a1s = 0; a2s = 0;
    mem_we = 0; wb_we = 0; mem_rd = 0; wb_rd = 0; mem_d = 0; wb_d = 0;
    #3;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_alu_in1", alu_in1, 0);
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1 rst_n = 1'b1;

    in_valid = 1; a2s = 0; rs2_a = 2;
    for (int i = 0; i < 5; i++) begin
      rs2_d = rs2_vec[i];
      step();
      chk("rs2_path", alu_in2, rs2_vec[i]);
    end
    a2s = 1;
    for (int i = 0; i < 6; i++) begin
      imm = imm_vec[i];
      step();
      chk("imm_path", alu_in2, imm_vec[i]);
    end
    a2s = 2; step(); chk("const4", alu_in2, 32'd4);
    a2s = 3; step(); chk("zero2", alu_in2, 32'd0);
    a1s = 1; pc = 32'h1000; step(); chk("pc_path", alu_in1, 32'h1000);
    a1s = 2; step(); chk("zero1", alu_in1, 32'd0);

    a1s = 0; rs1_a = 5; rs1_d = 7;
    mem_we = 1; mem_rd = 5; mem_d = 100; wb_we = 1; wb_rd = 5; wb_d = 200;
    step(); chk("fwd_mem", alu_in1, FWD_ON ? 32'd100 : 32'd7);
    mem_we = 0; step(); chk("fwd_wb", alu_in1, FWD_ON ? 32'd200 : 32'd7);
    rs1_a = 0; mem_we = 1; mem_rd = 0; wb_rd = 0; step(); chk("fwd_x0", alu_in1, 32'd7);
    a2s = 0; rs2_a = 3; rs2_d = 9; mem_rd = 4; wb_rd = 3; wb_d = 55;
    step(); chk("fwd_rs2_wb", alu_in2, FWD_ON ? 32'd55 : 32'd9);
    mem_we = 0; wb_we = 0;

    in_valid = 0; step(); chk("drain", 32'(out_valid), 0);
    in_valid = 1; a1s = 1; pc = 32'h44; a2s = 1; imm = 32'h77; out_ready = 0;
    step(); chk("stall_cap", alu_in1, 32'h44);
    pc = 32'h88;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ready", 32'(in_ready), 0);
      chk("stall_hold", alu_in1, 32'h44);
    end
    chk("stall_cnt3", 32'(stall_cnt), 3);
    stall_clr = 1; step(); chk("stall_clr", 32'(stall_cnt), 0);
    stall_clr = 0;
    repeat (20) step();
    chk("stall_sat", 32'(stall_cnt), 15);
    stall_clr = 1; step(); stall_clr = 0;
    repeat (5) step();
    chk("stall_cnt5", 32'(stall_cnt), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_in1", alu_in1, 0);
    chk("async_in2", alu_in2, 0);
    chk("async_cnt", 32'(stall_cnt), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    out_ready = 1; in_valid = 1; pc = 32'h10;
    step(); chk("pre_flush", alu_in1, 32'h10);
    out_ready = 0; flush = 1; pc = 32'h20;
    #1 chk("flush_ready", 32'(in_ready), 0);
    step();
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_hold", alu_in1, 32'h10);
    out_ready = 1; pc = 32'h30;
    step();
    chk("flush_rdy_valid", 32'(out_valid), 0);
    chk("flush_rdy_hold", alu_in1, 32'h10);
    flush = 0; step(); chk("post_flush", alu_in1, 32'h30);
    in_valid = 0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Registered operand-select stage between the register file and the ALU of the core. It builds both ALU operands from register data, PC, immediate or constants, resolves read-after-write hazards by forwarding from the MEM and WB stages, and holds the result in a one-entry pipeline register with a valid/ready handshake. It generalises the two-input ALU input-2 mux to a width-parametrised, dual-operand, stall- and flush-aware stage, and adds a saturating stall counter for performance monitoring.

## Interface
- XLEN, 32, operand/data width
- RA_W, 5, register address width
- CNT_W, 16, stall counter width
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode stage offers an operation
- in_ready  out  1  stage accepts this cycle
- rs1_a, rs2_a  in  RA_W  source register addresses
- rs1_d, rs2_d  in  XLEN  register file read data
- pc  in  XLEN  instruction address
- imm  in  XLEN  sign-extended immediate
- alu1_sel  in  2  0 rs1, 1 pc, 2/3 zero
- alu2_sel  in  2  0 rs2, 1 imm, 2 constant 4, 3 zero
- fwd_mem_we, fwd_wb_we  in  1  MEM/WB stage will write a register
- fwd_mem_rd, fwd_wb_rd  in  RA_W  MEM/WB destination address
- fwd_mem_d, fwd_wb_d  in  XLEN  MEM/WB result data
- flush  in  1  synchronous pipeline flush
- out_valid  out  1  registered operands valid
- out_ready  in  1  ALU/EX consumes operands
- alu_in1, alu_in2  out  XLEN  registered ALU operands
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready
- stall_clr  in  1  synchronous clear of stall_cnt

## Operation
- Register-source resolution (per operand, rsX): if fwd_mem_we && fwd_mem_rd==rsX_a && rsX_a!=0 -> fwd_mem_d; else if fwd_wb_we && fwd_wb_rd==rsX_a && rsX_a!=0 -> fwd_wb_d; else rsX_d. MEM has priority over WB. Register x0 never forwarded.
- Forwarding applies only when the select chooses rs1/rs2; pc, imm and constants pass unchanged.
- Constant 4 is zero-extended to XLEN; all paths are XLEN wide, no truncation or extension inside the block.
- in_ready = !flush && (!out_valid || out_ready) (combinational).
- Capture: in_valid && in_ready at clock edge -> alu_in1/alu_in2 load resolved operands, out_valid<=1.
- Drain: out_valid && out_ready && !capture -> out_valid<=0; alu_in1/alu_in2 hold last value.
- Stall: out_valid && !out_ready -> all outputs hold; in_ready=0.
- flush has priority: out_valid<=0, no capture that cycle, operand registers hold.
- stall_cnt: +1 each cycle out_valid && !out_ready, saturates at 2^CNT_W-1; stall_clr has priority over increment (clears to 0).

## Timing
- Latency 1 cycle from accepted input to out_valid/operands.
- Full throughput: back-to-back transfers when out_ready held high.
- Forward inputs sampled in the capture cycle only; later changes do not affect held operands.
- Reset (rst_n low, any time, including mid-stall): out_valid=0, alu_in1=0, alu_in2=0, stall_cnt=0 immediately; in_ready=1 while flush low.
- Simultaneous flush and out_ready: out_valid cleared, no new capture.
- Simultaneous stall_clr and stall cycle: stall_cnt=0.

## Configuration
- ALU_OPERAND_FWD_EN defined: forwarding as described.
- Not defined: forwarding logic removed; fwd_* ports remain but are ignored; register sources are always rs1_d/rs2_d.

## Test plan
- alu2_sel=0, rs2_d=10, then 3, -4, 4, -16 with out_ready=1 -> alu_in2 follows one cycle later each; alu2_sel=1, imm=0,1,2,10,-16,-4 -> alu_in2 equals imm sequence; alu2_sel=2 -> 4.
- alu1_sel=0, rs1_a=5, rs1_d=7, fwd_mem_we=1 rd=5 d=100, fwd_wb_we=1 rd=5 d=200 -> alu_in1=100; MEM we=0 -> 200; rs1_a=0 with both matching rd=0 -> rs1_d (with macro off: always 7).
- out_ready=0 for 3 cycles after a capture -> in_ready=0, operands hold, stall_cnt=3; stall_clr pulse -> 0; CNT_W=4 and 20 stall cycles -> 15.
- flush asserted with in_valid=1 and out_valid=1 -> next cycle out_valid=0, operands unchanged, no capture.
- rst_n pulled low mid-stall with out_valid=1, stall_cnt=5 -> out_valid=0, alu_in1=alu_in2=0, stall_cnt=0 without a clock edge.
